decimation_sequencer: RTL and testbench

Parametrised decimation timing generator for the capture path. It issues a one-cycle write strobe every N+1 clocks while a capture is armed, and adds a delayed clock-enable copy. It also provides a window-start marker and a min/max select for peak-detect mode. A programmable strobe count ends the capture on its own with a sticky DONE flag. It sits between the capture control register block and the sample RAM write logic.

---
 rtl/decimation_sequencer.sv | 143 ++++++++++++++
 tb/tb_decimation_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decimation_sequencer.sv
// Decimation timing generator: one-cycle write strobe every N+1 clocks while armed,
// with a trailing clock-enable copy, window-start marker, peak-detect select and counted stop.
module decimation_sequencer #(
  parameter int CNT_W  = 24,
  parameter int SCNT_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  dec_in,
  input  logic [SCNT_W-1:0] samples,
  input  logic              peak_mode,
  input  logic              start,
  output logic              en,
  output logic              clk_en,
  output logic              win_first,
  output logic              minmax_sel,
  output logic              busy,
  output logic              done,
  output logic [SCNT_W-1:0] strobe_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [SCNT_W-1:0] SCNT_ONE = 1;

  state_t            state, next_state;
  logic [CNT_W-1:0]  dec_cnt, next_dec_cnt;
  logic [CNT_W-1:0]  cfg_n, next_cfg_n;
  logic [SCNT_W-1:0] cfg_samples, next_cfg_samples;
  logic              cfg_peak, next_cfg_peak;
  logic              next_en, next_clk_en, next_win_first, next_minmax_sel;
  logic              next_busy, next_done;
  logic [SCNT_W-1:0] next_strobe_cnt;
  logic [SCNT_W-1:0] strobe_inc;

  assign strobe_inc = strobe_cnt + SCNT_ONE;

  // Next-state and next-output logic; configuration is frozen once RUN is entered.
  always_comb begin
    next_state       = state;
    next_dec_cnt     = dec_cnt;
    next_cfg_n       = cfg_n;
    next_cfg_samples = cfg_samples;
    next_cfg_peak    = cfg_peak;
    next_en          = 1'b0;
    next_clk_en      = en;
    next_win_first   = 1'b0;
    next_minmax_sel  = minmax_sel;
    next_busy        = busy;
    next_done        = done;
    next_strobe_cnt  = strobe_cnt;

    case (state)
      ST_IDLE: begin
        next_cfg_n       = dec_in;
        next_cfg_samples = samples;
        next_cfg_peak    = peak_mode;
        next_dec_cnt     = dec_in;
        next_strobe_cnt  = '0;
        next_minmax_sel  = 1'b0;
        next_done        = 1'b0;
        next_busy        = start;
        next_win_first   = start;
        if (start) begin
          next_state = ST_RUN;
        end
      end

      ST_RUN: begin
        if (cfg_peak && en) begin
          next_minmax_sel = ~minmax_sel;
        end
        // Abort takes priority over a strobe that would fall on the same edge.
        if (!start) begin
          next_state = ST_IDLE;
          next_busy  = 1'b0;
        end else if (dec_cnt == '0) begin
          next_dec_cnt    = cfg_n;
          next_en         = 1'b1;
          next_strobe_cnt = strobe_inc;
          if ((cfg_samples != '0) && (strobe_inc == cfg_samples)) begin
            next_state = ST_DONE;
            next_busy  = 1'b0;
            next_done  = 1'b1;
          end else begin
            next_win_first = 1'b1;
          end
        end else begin
          next_dec_cnt = dec_cnt - CNT_ONE;
        end
      end

      ST_DONE: begin
        next_busy = 1'b0;
        next_done = 1'b1;
        if (!start) begin
          next_state = ST_IDLE;
          next_done  = 1'b0;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dec_cnt     <= '0;
      cfg_n       <= '0;
      cfg_samples <= '0;
      cfg_peak    <= 1'b0;
      en          <= 1'b0;
      clk_en      <= 1'b0;
      win_first   <= 1'b0;
      minmax_sel  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      strobe_cnt  <= '0;
    end else begin
      state       <= next_state;
      dec_cnt     <= next_dec_cnt;
      cfg_n       <= next_cfg_n;
      cfg_samples <= next_cfg_samples;
      cfg_peak    <= next_cfg_peak;
      en          <= next_en;
      clk_en      <= next_clk_en;
      win_first   <= next_win_first;
      minmax_sel  <= next_minmax_sel;
      busy        <= next_busy;
      done        <= next_done;
      strobe_cnt  <= next_strobe_cnt;
    end
  end

endmodule

// File: tb/tb_decimation_sequencer.sv
// Directed bench for decimation_sequencer; flag vectors are ordered
// {en, clk_en, win_first, minmax_sel, busy, done}.
module tb_decimation_sequencer;

  localparam int CNT_W  = 24;
  localparam int SCNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic [CNT_W-1:0]  dec_in;
  logic [SCNT_W-1:0] samples;
  logic              peak_mode;
  logic              start;
  logic              en;
  logic              clk_en;
  logic              win_first;
  logic              minmax_sel;
  logic              busy;
  logic              done;
  logic [SCNT_W-1:0] strobe_cnt;

  int total = 0;
  int bad   = 0;

  decimation_sequencer #(
    .CNT_W (CNT_W),
    .SCNT_W(SCNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec_in    (dec_in),
    .samples   (samples),
    .peak_mode (peak_mode),
    .start     (start),
    .en        (en),
    .clk_en    (clk_en),
    .win_first (win_first),
    .minmax_sel(minmax_sel),
    .busy      (busy),
    .done      (done),
    .strobe_cnt(strobe_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] n,
                               input logic [SCNT_W-1:0] smp, input logic pk);
    start     = s;
    dec_in    = n;
    samples   = smp;
    peak_mode = pk;
  endtask

  task automatic checkFlags(input string tag, input logic [5:0] exp_flags);
    logic [5:0] obs;
    obs = {en, clk_en, win_first, minmax_sel, busy, done};
    total++;
    assert (obs === exp_flags) else begin
      bad++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", tag, obs, exp_flags);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] exp_flags,
                             input logic [SCNT_W-1:0] exp_cnt);
    logic [5+SCNT_W:0] obs;
    logic [5+SCNT_W:0] expv;
    obs  = {en, clk_en, win_first, minmax_sel, busy, done, strobe_cnt};
    expv = {exp_flags, exp_cnt};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s flags observed=%b expected=%b cnt observed=%0d expected=%0d",
             tag, obs[5+SCNT_W:SCNT_W], exp_flags, obs[SCNT_W-1:0], exp_cnt);
    end
  endtask

  initial begin
    logic [5:0] ef;
    logic       mm;

    rst_n = 1'b0;
    applyStimulus(1'b0, 24'd3, 8'd4, 1'b0);
    #3;
    checkOutput("reset", 6'b000000, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("idle", 6'b000000, 8'd0);

    $display("[TB] counted capture N=3 SAMPLES=4");
    applyStimulus(1'b1, 24'd3, 8'd4, 1'b0);
    step();
    checkOutput("t1 arm", 6'b001010, 8'd0);
    for (int s = 1; s <= 4; s++) begin
      step();
      ef = {1'b0, (s > 1), 4'b0010};
      checkOutput("t1 gap", ef, SCNT_W'(s - 1));
      for (int g = 0; g < 2; g++) begin
        step();
        checkOutput("t1 quiet", 6'b000010, SCNT_W'(s - 1));
      end
      step();
      ef = (s < 4) ? 6'b101010 : 6'b100001;
      checkOutput("t1 strobe", ef, SCNT_W'(s));
    end
    step();
    checkOutput("t1 done trail", 6'b010001, 8'd4);
    step();
    checkOutput("t1 done hold", 6'b000001, 8'd4);

    $display("[TB] change period while in DONE, then re-arm");
    applyStimulus(1'b1, 24'd1, 8'd4, 1'b0);
    step();
    checkOutput("t5 done held", 6'b000001, 8'd4);
    step();
    checkOutput("t5 done held2", 6'b000001, 8'd4);
    start = 1'b0;
    step();
    checkFlags("t5 exit", 6'b000000);
    step();
    checkOutput("t5 idle", 6'b000000, 8'd0);
    start = 1'b1;
    step();
    checkOutput("t5 arm", 6'b001010, 8'd0);
    step();
    checkOutput("t5 quiet", 6'b000010, 8'd0);
    step();
    checkOutput("t5 strobe1", 6'b101010, 8'd1);
    step();
    checkOutput("t5 gap", 6'b010010, 8'd1);
    step();
    checkOutput("t5 strobe2", 6'b101010, 8'd2);
    start = 1'b0;
    step();
    checkFlags("t5 abort", 6'b010000);
    step();
    checkOutput("t5 idle2", 6'b000000, 8'd0);

    $display("[TB] peak mode N=5 SAMPLES=6");
    applyStimulus(1'b1, 24'd5, 8'd6, 1'b1);
    step();
    checkOutput("t3 arm", 6'b001010, 8'd0);
    for (int s = 1; s <= 6; s++) begin
      mm = ((s - 1) % 2) == 1;
      for (int g = 0; g < 5; g++) begin
        step();
        ef = {1'b0, (s > 1 && g == 0), 1'b0, mm, 2'b10};
        checkOutput("t3 quiet", ef, SCNT_W'(s - 1));
      end
      step();
      ef = (s < 6) ? {3'b101, mm, 2'b10} : {3'b100, mm, 2'b01};
      checkOutput("t3 strobe", ef, SCNT_W'(s));
    end
    step();
    checkOutput("t3 done", 6'b010101, 8'd6);
    start = 1'b0;
    step();
    checkFlags("t3 exit", 6'b000100);
    step();
    checkOutput("t3 idle", 6'b000000, 8'd0);

    $display("[TB] abort on the reload edge N=7");
    applyStimulus(1'b1, 24'd7, 8'd0, 1'b0);
    step();
    checkOutput("t4 arm", 6'b001010, 8'd0);
    for (int g = 0; g < 7; g++) begin
      step();
      checkOutput("t4 count", 6'b000010, 8'd0);
    end
    start = 1'b0;
    step();
    checkOutput("t4 abort", 6'b000000, 8'd0);
    step();
    checkOutput("t4 idle", 6'b000000, 8'd0);

    $display("[TB] free run N=0 with counter wrap");
    applyStimulus(1'b1, 24'd0, 8'd0, 1'b0);
    step();
    checkOutput("t2 arm", 6'b001010, 8'd0);
    step();
    checkOutput("t2 first", 6'b101010, 8'd1);
    for (int j = 2; j <= 260; j++) begin
      step();
      checkOutput("t2 run", 6'b111010, SCNT_W'(j));
    end
    start = 1'b0;
    step();
    checkFlags("t2 abort", 6'b010000);
    step();
    checkOutput("t2 idle", 6'b000000, 8'd0);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b1, 24'd2, 8'd0, 1'b1);
    step();
    checkOutput("t6 arm", 6'b001010, 8'd0);
    step();
    checkOutput("t6 q1", 6'b000010, 8'd0);
    step();
    checkOutput("t6 q2", 6'b000010, 8'd0);
    step();
    checkOutput("t6 strobe", 6'b101010, 8'd1);
    step();
    checkOutput("t6 toggle", 6'b010110, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async rst", 6'b000000, 8'd0);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("t6 rearm", 6'b001010, 8'd0);
    step();
    checkOutput("t6 rq1", 6'b000010, 8'd0);
    step();
    checkOutput("t6 rq2", 6'b000010, 8'd0);
    step();
    checkOutput("t6 rstrobe", 6'b101010, 8'd1);
    start = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
